// File: rtl/pc_ctrl_pkg.sv
// rtl/pc_ctrl_pkg.sv - shared types and constants for the next-PC sequencer
package pc_ctrl_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        ST_BOOT     = 2'd0,
        ST_RUN      = 2'd1,
        ST_WAIT_ACK = 2'd2
    } pc_state_e;

    localparam logic [1:0] PC_SEL_HOLD = 2'd0;
    localparam logic [1:0] PC_SEL_INC  = 2'd1;
    localparam logic [1:0] PC_SEL_BR   = 2'd2;
    localparam logic [1:0] PC_SEL_TRAP = 2'd3;

endpackage

// File: rtl/pc_redirect_buf.sv
// rtl/pc_redirect_buf.sv - pending-redirect register; a trap overwrites a pending branch, never the reverse
module pc_redirect_buf
    import pc_ctrl_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_capture,
    input  logic            i_clear,
    input  logic            i_trap,
    input  logic [XLEN-1:0] i_trap_addr,
    input  logic            i_branch,
    input  logic [XLEN-1:0] i_branch_addr,
    output logic            o_pend_vld,
    output logic            o_pend_trap,
    output logic [XLEN-1:0] o_pend_addr
);

    logic            r_vld;
    logic            r_trap;
    logic [XLEN-1:0] r_addr;

    always_ff @(posedge i_clk) begin
        if (i_rst || i_clear) begin
            r_vld  <= 1'b0;
            r_trap <= 1'b0;
            r_addr <= '0;
        end else if (i_capture) begin
            if (i_trap) begin
                r_vld  <= 1'b1;
                r_trap <= 1'b1;
                r_addr <= i_trap_addr;
            end else if (i_branch && !(r_vld && r_trap)) begin
                r_vld  <= 1'b1;
                r_trap <= 1'b0;
                r_addr <= i_branch_addr;
            end
        end
    end

    assign o_pend_vld  = r_vld;
    assign o_pend_trap = r_trap;
    assign o_pend_addr = r_addr;

endmodule

// File: rtl/pc_ctrl.sv
// rtl/pc_ctrl.sv - next-PC sequencer with imem handshake; PC_CTRL_MISALIGN_CHK_EN enables misaligned-branch trapping
module pc_ctrl
    import pc_ctrl_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_VECTOR = 32'h0000_0000,
    parameter int              PC_INC       = 4
) (
    input  logic            clk_in,
    input  logic            rst_in,
    input  logic [XLEN-1:0] pc_in,
    input  logic            stall_in,
    input  logic            branch_taken_in,
    input  logic [XLEN-1:0] branch_target_in,
    input  logic            trap_in,
    input  logic [XLEN-1:0] trap_vector_in,
    input  logic            imem_ack_in,
    output logic [XLEN-1:0] next_pc_out,
    output logic [1:0]      pc_sel_out,
    output logic            imem_req_out,
    output logic            flush_out
`ifdef PC_CTRL_MISALIGN_CHK_EN
    ,
    output logic            misalign_out
`endif
);

    localparam logic [XLEN-1:0] LP_INC = XLEN'(PC_INC);

    pc_state_e       r_state;
    pc_state_e       w_state_nxt;
    logic            w_pend_vld;
    logic            w_pend_trap;
    logic [XLEN-1:0] w_pend_addr;
    logic            w_capture;
    logic            w_clear;
    logic            w_redir_vld;
    logic            w_redir_trap;
    logic [XLEN-1:0] w_redir_addr;
    logic            w_mis;

    pc_redirect_buf u_redirect_buf (
        .i_clk         (clk_in),
        .i_rst         (rst_in),
        .i_capture     (w_capture),
        .i_clear       (w_clear),
        .i_trap        (trap_in),
        .i_trap_addr   (trap_vector_in),
        .i_branch      (branch_taken_in),
        .i_branch_addr (branch_target_in),
        .o_pend_vld    (w_pend_vld),
        .o_pend_trap   (w_pend_trap),
        .o_pend_addr   (w_pend_addr)
    );

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            r_state <= ST_BOOT;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        next_pc_out  = pc_in;
        pc_sel_out   = PC_SEL_HOLD;
        imem_req_out = 1'b0;
        w_capture    = 1'b0;
        w_clear      = 1'b0;
        w_redir_vld  = 1'b0;
        w_redir_trap = 1'b0;
        w_redir_addr = pc_in;

        case (r_state)
            ST_BOOT: begin
                next_pc_out = RESET_VECTOR;
                w_state_nxt = ST_RUN;
            end
            ST_RUN: begin
                imem_req_out = !stall_in;
                if (trap_in || branch_taken_in) begin
                    w_redir_vld  = 1'b1;
                    w_redir_trap = trap_in;
                    w_redir_addr = trap_in ? trap_vector_in : branch_target_in;
                end else if (!stall_in) begin
                    if (imem_ack_in) begin
                        next_pc_out = pc_in + LP_INC;
                        pc_sel_out  = PC_SEL_INC;
                    end else begin
                        w_state_nxt = ST_WAIT_ACK;
                    end
                end
            end
            ST_WAIT_ACK: begin
                // An issued request stays up until acked, even across stalls
                imem_req_out = 1'b1;
                if (imem_ack_in) begin
                    w_clear     = 1'b1;
                    w_state_nxt = ST_RUN;
                    if (trap_in || branch_taken_in) begin
                        w_redir_vld  = 1'b1;
                        w_redir_trap = trap_in;
                        w_redir_addr = trap_in ? trap_vector_in : branch_target_in;
                    end else if (w_pend_vld) begin
                        w_redir_vld  = 1'b1;
                        w_redir_trap = w_pend_trap;
                        w_redir_addr = w_pend_addr;
                    end else begin
                        next_pc_out = pc_in + LP_INC;
                        pc_sel_out  = PC_SEL_INC;
                    end
                end else begin
                    w_capture = 1'b1;
                end
            end
            default: w_state_nxt = ST_BOOT;
        endcase

`ifdef PC_CTRL_MISALIGN_CHK_EN
        w_mis = w_redir_vld && !w_redir_trap && (w_redir_addr[1:0] != 2'b00);
`else
        w_mis = 1'b0;
`endif

        // A misaligned branch is turned into a trap to the current handler address
        if (w_redir_vld) begin
            if (w_redir_trap || w_mis) begin
                next_pc_out = w_redir_trap ? w_redir_addr : trap_vector_in;
                pc_sel_out  = PC_SEL_TRAP;
            end else begin
                next_pc_out = w_redir_addr;
                pc_sel_out  = PC_SEL_BR;
            end
        end
        flush_out = w_redir_vld;

        if (rst_in) begin
            next_pc_out  = RESET_VECTOR;
            pc_sel_out   = PC_SEL_HOLD;
            imem_req_out = 1'b0;
            flush_out    = 1'b0;
        end
    end

`ifdef PC_CTRL_MISALIGN_CHK_EN
    assign misalign_out = w_mis && !rst_in;
`endif

endmodule
